// File: rtl/keypad_scanner_pkg.sv
// Shared keypad definitions: the no-key code, scan states and the 4x3 key map.
package keypad_scanner_pkg;

    // "No key" code, shared with the alarm-clock controller.
    localparam logic [3:0] NOKEY = 4'd10;

    // Scan sequencer states: one per driven column plus a one-clock evaluate slot.
    typedef enum logic [1:0] {
        SCAN0 = 2'd0,
        SCAN1 = 2'd1,
        SCAN2 = 2'd2,
        EVAL  = 2'd3
    } scan_state_e;

    // Map a (row, column) position to its digit; '*' and '#' become NOKEY.
    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        code = NOKEY;
        case (r)
            2'd0, 2'd1, 2'd2: begin
                if (c < 2'd3) begin
                    code = ({2'b00, r} * 4'd3) + {2'b00, c} + 4'd1;
                end else begin
                    code = NOKEY;
                end
            end
            2'd3: begin
                if (c == 2'd1) begin
                    code = 4'd0;
                end else begin
                    code = NOKEY;
                end
            end
            default: code = NOKEY;
        endcase
        return code;
    endfunction

    // Number of row lines that read high in one column sample.
    function automatic logic [2:0] count_rows(input logic [3:0] v);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 4; i++) begin
            n = n + {2'b00, v[i]};
        end
        return n;
    endfunction

    // Index of the highest row line that is high (only meaningful for a single hit).
    function automatic logic [1:0] row_index(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (v[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scanner_sync_2ff.sv
// Two-flop synchroniser for asynchronous pad inputs (rows now, buttons later).
module keypad_scanner_sync_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta_q <= {WIDTH{1'b0}};
            sync_q <= {WIDTH{1'b0}};
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 keypad scanner: column-at-a-time scan, per-sweep key code, sweep debounce.
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [2:0] col,
    output logic [3:0] key,
    output logic       key_strobe
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int SW = $clog2(DEBOUNCE + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DWELL_ONE  = DW'(1);
    localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE);
    localparam logic [SW-1:0] STABLE_ONE = SW'(1);

    logic [3:0]  row_sync_s;
    logic [2:0]  row_hits_s;
    logic [1:0]  col_idx_s;
    logic [3:0]  sweep_code_s;

    scan_state_e state_q, state_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [2:0]  col_q, col_d;
    logic [3:0]  code_q, code_d;
    logic        hit_q, hit_d;
    logic        bad_q, bad_d;
    logic [3:0]  cand_q, cand_d;
    logic [SW-1:0] stable_q, stable_d;
    logic        pend_q, pend_d;
    logic [3:0]  key_q, key_d;
    logic        strobe_q, strobe_d;

    keypad_scanner_sync_2ff #(.WIDTH(4)) u_row_sync (
        .clock (clock),
        .reset (reset),
        .d_i   (row),
        .q_o   (row_sync_s)
    );

    // Next-state logic for scan sequencing, sweep accumulation and debounce.
    always_comb begin
        state_d      = state_q;
        dwell_d      = dwell_q;
        col_d        = col_q;
        code_d       = code_q;
        hit_d        = hit_q;
        bad_d        = bad_q;
        cand_d       = cand_q;
        stable_d     = stable_q;
        pend_d       = 1'b0;
        key_d        = key_q;
        strobe_d     = 1'b0;
        row_hits_s   = count_rows(row_sync_s);
        col_idx_s    = state_q;
        sweep_code_s = bad_q ? NOKEY : code_q;

        // A debounce decision taken in EVAL lands on the key one clock later.
        if (pend_q) begin
            key_d    = cand_q;
            strobe_d = (cand_q != NOKEY);
        end else begin
            key_d    = key_q;
            strobe_d = 1'b0;
        end

        case (state_q)
            SCAN0, SCAN1, SCAN2: begin
                if (dwell_q == DWELL_LAST) begin
                    dwell_d = {DW{1'b0}};
                    // Single hit sets the code; multiple rows or a second column invalidate.
                    if (row_hits_s == 3'd1) begin
                        if (hit_q) begin
                            bad_d = 1'b1;
                        end else begin
                            code_d = key_map(row_index(row_sync_s), col_idx_s);
                            hit_d  = 1'b1;
                        end
                    end else if (row_hits_s > 3'd1) begin
                        bad_d = 1'b1;
                    end else begin
                        bad_d = bad_q;
                    end
                    case (state_q)
                        SCAN0: begin
                            state_d = SCAN1;
                            col_d   = 3'b010;
                        end
                        SCAN1: begin
                            state_d = SCAN2;
                            col_d   = 3'b100;
                        end
                        default: begin
                            state_d = EVAL;
                            col_d   = 3'b001;
                        end
                    endcase
                end else begin
                    dwell_d = dwell_q + DWELL_ONE;
                end
            end
            EVAL: begin
                state_d = SCAN0;
                col_d   = 3'b001;
                dwell_d = {DW{1'b0}};
                if (sweep_code_s == cand_q) begin
                    cand_d   = cand_q;
                    stable_d = (stable_q == STABLE_MAX) ? STABLE_MAX : (stable_q + STABLE_ONE);
                end else begin
                    cand_d   = sweep_code_s;
                    stable_d = STABLE_ONE;
                end
                pend_d = (stable_d == STABLE_MAX) && (cand_d != key_q);
                // Fresh accumulator for the sweep that starts in SCAN0.
                code_d = NOKEY;
                hit_d  = 1'b0;
                bad_d  = 1'b0;
            end
            default: begin
                state_d = SCAN0;
                col_d   = 3'b001;
                dwell_d = {DW{1'b0}};
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= SCAN0;
            dwell_q  <= {DW{1'b0}};
            col_q    <= 3'b001;
            code_q   <= NOKEY;
            hit_q    <= 1'b0;
            bad_q    <= 1'b0;
            cand_q   <= NOKEY;
            stable_q <= {SW{1'b0}};
            pend_q   <= 1'b0;
            key_q    <= NOKEY;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            dwell_q  <= dwell_d;
            col_q    <= col_d;
            code_q   <= code_d;
            hit_q    <= hit_d;
            bad_q    <= bad_d;
            cand_q   <= cand_d;
            stable_q <= stable_d;
            pend_q   <= pend_d;
            key_q    <= key_d;
            strobe_q <= strobe_d;
        end
    end

    assign col        = col_q;
    assign key        = key_q;
    assign key_strobe = strobe_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with a per-sweep reference model.
module tb_keypad_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE = 3;
    localparam int SWEEP    = 3 * SCAN_DIV + 1;
    localparam logic [3:0]  NK     = 4'd10;
    localparam logic [11:0] STAR_M = 12'h200;
    localparam logic [11:0] HASH_M = 12'h800;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  row;
    logic [2:0]  col;
    logic [3:0]  key;
    logic        key_strobe;
    logic [11:0] mask;

    int tests   = 0;
    int fails   = 0;
    int strobes = 0;

    logic [3:0] m_key;
    logic       m_pend;
    logic [3:0] m_pend_val;
    logic [3:0] hist[$];

    keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
        .clock      (clock),
        .reset      (reset),
        .row        (row),
        .col        (col),
        .key        (key),
        .key_strobe (key_strobe)
    );

    always #5 clock = ~clock;

    // Keypad matrix: a pressed key connects its column drive to its row line.
    always_comb begin
        row = 4'b0000;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (mask[r*3+c] && col[c]) row[r] = 1'b1;
            end
        end
    end

    function automatic logic [11:0] key_mask(input int d);
        if (d == 0) return 12'h400;
        return 12'h001 << (d - 1);
    endfunction

    // Code a full sweep reports: exactly one closed key gives its digit, anything else NOKEY.
    function automatic logic [3:0] model_sweep(input logic [11:0] m);
        int idx;
        if ($countones(m) != 1) return NK;
        idx = 0;
        for (int i = 0; i < 12; i++) if (m[i]) idx = i;
        if (idx < 9) return 4'(idx + 1);
        if (idx == 10) return 4'd0;
        return NK;
    endfunction

    task automatic model_reset();
        hist.delete();
        m_key  = NK;
        m_pend = 1'b0;
        m_pend_val = NK;
    endtask

    // One full sweep with keys m held; checks col/key/strobe every clock.
    task automatic run_sweep(input logic [11:0] m);
        logic [2:0] exp_col;
        logic       exp_strobe;
        logic       same;
        for (int k = 0; k < SWEEP; k++) begin
            if (k == 1 && m_pend) begin
                m_key      = m_pend_val;
                exp_strobe = (m_pend_val != NK);
                m_pend     = 1'b0;
            end else begin
                exp_strobe = 1'b0;
            end
            if (k < SCAN_DIV) exp_col = 3'b001;
            else if (k < 2 * SCAN_DIV) exp_col = 3'b010;
            else if (k < 3 * SCAN_DIV) exp_col = 3'b100;
            else exp_col = 3'b001;
            tests++;
            if (col !== exp_col) begin
                fails++;
                $display("FAIL col cycle %0d: got %b expected %b", k, col, exp_col);
            end
            tests++;
            if (key !== m_key) begin
                fails++;
                $display("FAIL key cycle %0d: got %0d expected %0d", k, key, m_key);
            end
            tests++;
            if (key_strobe !== exp_strobe) begin
                fails++;
                $display("FAIL strobe cycle %0d: got %b expected %b", k, key_strobe, exp_strobe);
            end
            if (key_strobe === 1'b1) strobes++;
            if (k == 0) mask = m;
            @(posedge clock);
            @(negedge clock);
        end
        hist.push_back(model_sweep(m));
        if (hist.size() > DEBOUNCE) void'(hist.pop_front());
        if (hist.size() == DEBOUNCE) begin
            same = 1'b1;
            foreach (hist[i]) if (hist[i] != hist[0]) same = 1'b0;
            if (same && hist[0] != m_key) begin
                m_pend     = 1'b1;
                m_pend_val = hist[0];
            end
        end
    endtask

    task automatic sweeps(input int n, input logic [11:0] m);
        for (int i = 0; i < n; i++) run_sweep(m);
    endtask

    task automatic test_reset();
        mask  = 12'h000;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        tests++;
        if (col !== 3'b001 || key !== NK || key_strobe !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: got col=%b key=%0d strobe=%b expected 001/10/0", col, key, key_strobe);
        end
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_idle();
        int s0;
        s0 = strobes;
        sweeps(10, 12'h000);
        tests++;
        if (key !== NK || strobes != s0) begin
            fails++;
            $display("FAIL idle: got key=%0d strobes=%0d expected 10/0", key, strobes - s0);
        end
    endtask

    task automatic test_hold5();
        int s0;
        s0 = strobes;
        sweeps(3, key_mask(5));
        tests++;
        if (key !== NK) begin
            fails++;
            $display("FAIL hold5_early: got %0d expected 10", key);
        end
        sweeps(1, key_mask(5));
        tests++;
        if (key !== 4'd5) begin
            fails++;
            $display("FAIL hold5_key: got %0d expected 5", key);
        end
        sweeps(19, key_mask(5));
        tests++;
        if (key !== 4'd5 || strobes - s0 != 1) begin
            fails++;
            $display("FAIL hold5_hold: got key=%0d strobes=%0d expected 5/1", key, strobes - s0);
        end
    endtask

    task automatic test_release();
        int s0;
        s0 = strobes;
        sweeps(3, 12'h000);
        tests++;
        if (key !== 4'd5) begin
            fails++;
            $display("FAIL release_early: got %0d expected 5", key);
        end
        sweeps(1, 12'h000);
        tests++;
        if (key !== NK || strobes != s0) begin
            fails++;
            $display("FAIL release: got key=%0d strobes=%0d expected 10/0", key, strobes - s0);
        end
    endtask

    task automatic test_bounce();
        int s0;
        s0 = strobes;
        sweeps(2, key_mask(5));
        sweeps(1, 12'h000);
        sweeps(2, key_mask(5));
        sweeps(4, 12'h000);
        tests++;
        if (key !== NK || strobes != s0) begin
            fails++;
            $display("FAIL bounce: got key=%0d strobes=%0d expected 10/0", key, strobes - s0);
        end
    endtask

    task automatic test_invalid();
        int s0;
        logic [11:0] pats [4];
        pats[0] = key_mask(1) | key_mask(2);
        pats[1] = key_mask(1) | key_mask(4);
        pats[2] = STAR_M;
        pats[3] = HASH_M;
        for (int p = 0; p < 4; p++) begin
            s0 = strobes;
            sweeps(5, pats[p]);
            tests++;
            if (key !== NK || strobes != s0) begin
                fails++;
                $display("FAIL invalid_%0d: got key=%0d strobes=%0d expected 10/0", p, key, strobes - s0);
            end
        end
        sweeps(3, 12'h000);
    endtask

    task automatic test_back_to_back();
        int s0;
        s0 = strobes;
        sweeps(4, key_mask(7));
        tests++;
        if (key !== 4'd7) begin
            fails++;
            $display("FAIL switch_7: got %0d expected 7", key);
        end
        sweeps(4, key_mask(0));
        tests++;
        if (key !== 4'd0 || strobes - s0 != 2) begin
            fails++;
            $display("FAIL switch_0: got key=%0d strobes=%0d expected 0/2", key, strobes - s0);
        end
        sweeps(4, 12'h000);
    endtask

    task automatic test_reset_mid();
        sweeps(4, key_mask(9));
        repeat (5) @(posedge clock);
        #2 reset = 1'b1;
        #1;
        tests++;
        if (col !== 3'b001 || key !== NK || key_strobe !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid: got col=%b key=%0d strobe=%b expected 001/10/0", col, key, key_strobe);
        end
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        sweeps(3, key_mask(9));
        tests++;
        if (key !== NK) begin
            fails++;
            $display("FAIL reset_mid_early: got %0d expected 10", key);
        end
        sweeps(1, key_mask(9));
        tests++;
        if (key !== 4'd9) begin
            fails++;
            $display("FAIL reset_mid_9: got %0d expected 9", key);
        end
        sweeps(4, 12'h000);
    endtask

    task automatic test_random();
        logic [11:0] m;
        int kind;
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(3, 0);
            if (kind == 0) m = 12'h000;
            else if (kind == 3) m = (12'h001 << $urandom_range(11, 0)) | (12'h001 << $urandom_range(11, 0));
            else m = 12'h001 << $urandom_range(11, 0);
            sweeps($urandom_range(5, 1), m);
        end
        sweeps(4, 12'h000);
    endtask

    initial begin
        reset = 1'b1;
        mask  = 12'h000;
        model_reset();
        @(negedge clock);
        test_reset();
        test_idle();
        test_hold5();
        test_release();
        test_bounce();
        test_invalid();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
